serial_subtractor_32: RTL and testbench

//  Bit-serial, multi-cycle subtractor: D = A - B, one bit per clock, LSB first.

---
 rtl/serial_subtractor_32_if.sv | 29 ++
 rtl/serial_subtractor_32.sv | 137 +++++++++++++
 tb/tb_serial_subtractor_32.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_32_if.sv
// rtl/serial_subtractor_32_if.sv - start/done request and result bundle for the bit-serial subtractor
//
// Purpose: carries one subtract request (start, A, B) and its registered result
// (D, borrow, ovf) with the busy/done status.
// Modports:
//   master - requester: drives start/A/B, observes D/borrow/ovf/busy/done
//   slave  - subtractor: observes start/A/B, drives D/borrow/ovf/busy/done
interface serial_subtractor_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             borrow;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  D, borrow, ovf, busy, done
    );

    modport slave (
        input  start, A, B,
        output D, borrow, ovf, busy, done
    );
endinterface

// File: rtl/serial_subtractor_32.sv
// rtl/serial_subtractor_32.sv - bit-serial LSB-first subtractor, D = A - B
//
// Purpose: computes A - B one bit per clock through a single full-subtractor
// cell. An op accepted at edge t is finished by edge t+WIDTH; D/borrow/ovf are
// written on that edge and done is high for the following cycle (the DONE
// state). A start seen during DONE is accepted immediately, giving one op
// per WIDTH+1 cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any op and clears all outputs
//   bus   - serial_subtractor_32_if slave modport (start, A, B in;
//           D, borrow, ovf, busy, done out)
module serial_subtractor_32 #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_subtractor_32_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] d_out_q,  d_out_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic diff_bit;
    logic br_next;

    // Full-subtractor cell on the current LSBs.
    assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        d_out_d  = d_out_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                res_d  = {diff_bit, res_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Final bit: publish the result on this edge so the
                    // visible outputs change only alongside done.
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    d_out_d  = res_d;
                    borrow_d = br_next;
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_bit);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_out_q  <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            d_out_q  <= d_out_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.D      = d_out_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_serial_subtractor_32.sv
// tb/tb_serial_subtractor_32.sv - directed and random checks of serial_subtractor_32
module tb_serial_subtractor_32;
    localparam int W = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    serial_subtractor_32_if #(.WIDTH(W)) bus ();

    serial_subtractor_32 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and waits for done; cyc is the number of edges
    // from the accepting edge (counted as 1) to the edge after which done
    // is seen. Returns -1 if done never arrives.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (bus.done) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] d,
                                input logic br, input logic ov);
        check_eq({tag, "_D"}, 64'(bus.D), 64'(d));
        check_eq({tag, "_borrow"}, 64'(bus.borrow), 64'(br));
        check_eq({tag, "_ovf"}, 64'(bus.ovf), 64'(ov));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        int dones;
        logic [W-1:0] ra, rb;
        logic [W:0]   full;

        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        vecs[0] = '{32'd45,         32'd27,         32'd18,         1'b0, 1'b0};
        vecs[1] = '{32'd27,         32'd45,         32'hFFFF_FFEE,  1'b1, 1'b0};
        vecs[2] = '{32'd0,          32'd0,          32'd0,          1'b0, 1'b0};
        vecs[3] = '{32'd0,          32'd1,          32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1'b1};
        vecs[5] = '{32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_result("rst", 32'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Directed vectors, with latency, single-cycle done and busy checks.
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].a, vecs[v].b, cyc);
            check_eq($sformatf("lat_%0d", v), 64'(cyc), 64'(LAT));
            check_eq($sformatf("busy_at_done_%0d", v), 64'(bus.busy), 64'd0);
            check_result($sformatf("vec_%0d", v), vecs[v].d, vecs[v].br, vecs[v].ov);
            @(negedge clk);
            check_eq($sformatf("done_pulse_%0d", v), 64'(bus.done), 64'd0);
        end

        // Start during SHIFT is ignored; outputs hold the previous result.
        @(negedge clk);
        bus.A = 32'd5;
        bus.B = 32'd3;
        bus.start = 1'b1;
        dones = 0;
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 5) begin
                check_eq("hold_D", 64'(bus.D), 64'(32'h7FFF_FFFF));
                check_eq("busy_shift", 64'(bus.busy), 64'd1);
            end
            if (i == 10) begin
                bus.start = 1'b1;
                bus.A = 32'd100;
                bus.B = 32'd1;
            end
            if (i == 11) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                cyc = i;
                break;
            end
        end
        check_eq("ign_lat", 64'(cyc), 64'(LAT));
        check_eq("ign_D", 64'(bus.D), 64'd2);

        // Back-to-back: start held during DONE is accepted with no idle gap.
        bus.A = 32'd100;
        bus.B = 32'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("b2b_busy", 64'(bus.busy), 64'd1);
        check_eq("b2b_done_low", 64'(bus.done), 64'd0);
        check_eq("b2b_hold_D", 64'(bus.D), 64'd2);
        cyc = -1;
        for (int i = 2; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                cyc = i;
                break;
            end
        end
        check_eq("b2b_lat", 64'(cyc), 64'(LAT));
        check_eq("b2b_D", 64'(bus.D), 64'd99);
        check_eq("done_count", 64'(dones), 64'd2);

        // Reset in the middle of SHIFT aborts the op and clears outputs.
        @(negedge clk);
        bus.A = 32'd1000;
        bus.B = 32'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_done", 64'(bus.done), 64'd0);
        check_eq("abort_D", 64'(bus.D), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);

        run_op(32'd45, 32'd27, cyc);
        check_eq("post_abort_lat", 64'(cyc), 64'(LAT));
        check_result("post_abort", 32'd18, 1'b0, 1'b0);

        // Random pairs against a wide-subtraction reference.
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 0) rb = ra ^ (32'd1 << (k % 32));
            full = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, cyc);
            check_result("rand", full[W-1:0], full[W],
                         (ra[W-1] ^ rb[W-1]) & (ra[W-1] ^ full[W-1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
